// File: rtl/mem_access.sv
// Memory-access pipeline stage: turns load/store/LL/SC into single data-bus
// transactions with big-endian lane steering, load extension and LLbit updates.
module mem_access (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic        ex_we,
  input  logic [4:0]  ex_waddr,
  input  logic [31:0] ex_wdata,
  input  logic        ex_whilo,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic [3:0]  ex_memop,
  input  logic [31:0] ex_memaddr,
  input  logic [31:0] ex_memdata,
  input  logic        llbit_i,
  input  logic        wb_llbit_we,
  input  logic        wb_llbit_value,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        mem_we,
  output logic [4:0]  mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        mem_whilo,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        LLbit_we_o,
  output logic        LLbit_value_o,
  output logic        stallreq_mem,
  output logic        addr_err
);

  localparam int unsigned DW = 32;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LBU  = 4'd2;
  localparam logic [3:0] OP_LH   = 4'd3;
  localparam logic [3:0] OP_LHU  = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;
  localparam logic [3:0] OP_LL   = 4'd9;
  localparam logic [3:0] OP_SC   = 4'd10;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t state, next_state;

  logic [3:0]    op_q;
  logic [1:0]    off_q;
  logic [DW-1:0] result_q;
  logic          flush_q;

  logic          llbit_cur;
  logic          op_valid;
  logic          misaligned;
  logic          sc_fail;
  logic          issue;
  logic          capture;
  logic          kill;
  logic          op_we;
  logic [3:0]    op_sel;
  logic [DW-1:0] op_wdata;

  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[3:0]};

  // Big-endian load extraction and extension; SC success writes 1.
  function automatic logic [DW-1:0] load_extend(input logic [3:0]    op,
                                                input logic [1:0]    off,
                                                input logic [DW-1:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [DW-1:0] r;
    unique case (off)
      2'd0:    b = rd[31:24];
      2'd1:    b = rd[23:16];
      2'd2:    b = rd[15:8];
      default: b = rd[7:0];
    endcase
    h = off[1] ? rd[15:0] : rd[31:16];
    case (op)
      OP_LB:        r = {{24{b[7]}}, b};
      OP_LBU:       r = {24'd0, b};
      OP_LH:        r = {{16{h[15]}}, h};
      OP_LHU:       r = {16'd0, h};
      OP_LW, OP_LL: r = rd;
      OP_SC:        r = DW'(1);
      default:      r = '0;
    endcase
    return r;
  endfunction

  // Operation decode for the instruction currently in EX/MEM.
  always_comb begin
    llbit_cur  = wb_llbit_we ? wb_llbit_value : llbit_i;
    op_valid   = (ex_memop != OP_NONE) && (ex_memop <= OP_SC);
    misaligned = 1'b0;
    op_we      = 1'b0;
    op_sel     = 4'b0000;
    op_wdata   = ex_memdata;
    case (ex_memop)
      OP_LB, OP_LBU: op_sel = 4'b1000 >> ex_memaddr[1:0];
      OP_SB: begin
        op_sel   = 4'b1000 >> ex_memaddr[1:0];
        op_we    = 1'b1;
        op_wdata = {4{ex_memdata[7:0]}};
      end
      OP_LH, OP_LHU: begin
        op_sel     = ex_memaddr[1] ? 4'b0011 : 4'b1100;
        misaligned = ex_memaddr[0];
      end
      OP_SH: begin
        op_sel     = ex_memaddr[1] ? 4'b0011 : 4'b1100;
        op_we      = 1'b1;
        op_wdata   = {2{ex_memdata[15:0]}};
        misaligned = ex_memaddr[0];
      end
      OP_LW, OP_LL: begin
        op_sel     = 4'b1111;
        misaligned = (ex_memaddr[1:0] != 2'b00);
      end
      OP_SW, OP_SC: begin
        op_sel     = 4'b1111;
        op_we      = 1'b1;
        misaligned = (ex_memaddr[1:0] != 2'b00);
      end
      default: ;
    endcase
    sc_fail = (ex_memop == OP_SC) && !misaligned && !llbit_cur;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  // Next-state and stage outputs.
  always_comb begin
    next_state    = state;
    issue         = 1'b0;
    capture       = 1'b0;
    kill          = 1'b0;
    mem_we        = ex_we;
    mem_waddr     = ex_waddr;
    mem_wdata     = ex_wdata;
    mem_whilo     = ex_whilo;
    mem_hi        = ex_hi;
    mem_lo        = ex_lo;
    LLbit_we_o    = 1'b0;
    LLbit_value_o = 1'b0;
    stallreq_mem  = 1'b0;
    addr_err      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (flush) begin
          kill = 1'b1;
        end else if (!op_valid) begin
          // plain pass-through
        end else if (misaligned) begin
          addr_err = 1'b1;
          mem_we   = 1'b0;
        end else if (sc_fail) begin
          mem_we    = 1'b1;
          mem_wdata = '0;
        end else begin
          stallreq_mem = 1'b1;
          issue        = 1'b1;
          next_state   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stallreq_mem = 1'b1;
        mem_we       = 1'b0;
        if (dbus_ack) begin
          // A flush seen at any point of the transaction discards the result.
          capture    = !(flush || flush_q);
          next_state = (flush || flush_q) ? ST_IDLE : ST_DONE;
        end
      end
      ST_DONE: begin
        if (flush) begin
          kill       = 1'b1;
          next_state = ST_IDLE;
        end else begin
          if (op_q inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LL, OP_SC})
            mem_wdata = result_q;
          if (op_q == OP_LL) begin
            LLbit_we_o    = 1'b1;
            LLbit_value_o = 1'b1;
          end else if (op_q == OP_SC) begin
            LLbit_we_o    = 1'b1;
            LLbit_value_o = 1'b0;
          end
          if (!stall[4]) next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
    if (kill || !reset_n) begin
      mem_we        = 1'b0;
      mem_waddr     = '0;
      mem_wdata     = '0;
      mem_whilo     = 1'b0;
      mem_hi        = '0;
      mem_lo        = '0;
      LLbit_we_o    = 1'b0;
      LLbit_value_o = 1'b0;
    end
    if (!reset_n) begin
      stallreq_mem = 1'b0;
      addr_err     = 1'b0;
    end
  end

  // Bus request registers, transaction context and captured load result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_sel   <= '0;
      dbus_wdata <= '0;
      op_q       <= OP_NONE;
      off_q      <= 2'b00;
      result_q   <= '0;
      flush_q    <= 1'b0;
    end else if (issue) begin
      dbus_req   <= 1'b1;
      dbus_we    <= op_we;
      dbus_addr  <= {ex_memaddr[31:2], 2'b00};
      dbus_sel   <= op_sel;
      dbus_wdata <= op_wdata;
      op_q       <= ex_memop;
      off_q      <= ex_memaddr[1:0];
      flush_q    <= 1'b0;
    end else if (state == ST_WAIT) begin
      if (flush)    flush_q  <= 1'b1;
      if (dbus_ack) dbus_req <= 1'b0;
      if (capture)  result_q <= load_extend(op_q, off_q, dbus_rdata);
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: single-cycle decode vectors plus bus sequences.
module tb_mem_access;

  localparam logic [3:0] OP_NONE = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3,
                         OP_LHU = 4'd4, OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7,
                         OP_SW = 4'd8, OP_LL = 4'd9, OP_SC = 4'd10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  stall;
  logic        flush;
  logic        ex_we;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        ex_whilo;
  logic [31:0] ex_hi, ex_lo;
  logic [3:0]  ex_memop;
  logic [31:0] ex_memaddr, ex_memdata;
  logic        llbit_i, wb_llbit_we, wb_llbit_value;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi, mem_lo;
  logic        LLbit_we_o, LLbit_value_o;
  logic        stallreq_mem, addr_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_memop(ex_memop), .ex_memaddr(ex_memaddr),
    .ex_memdata(ex_memdata), .llbit_i(llbit_i), .wb_llbit_we(wb_llbit_we),
    .wb_llbit_value(wb_llbit_value), .dbus_req(dbus_req), .dbus_we(dbus_we),
    .dbus_addr(dbus_addr), .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .LLbit_we_o(LLbit_we_o),
    .LLbit_value_o(LLbit_value_o), .stallreq_mem(stallreq_mem), .addr_err(addr_err)
  );

  task automatic chk(input string nm, input string f, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %h, expected %h", nm, f, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction: decode, WAIT for dly cycles, ack, DONE (held for hold cycles).
  task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] rdata,
                        input int dly, input int hold,
                        input logic e_bwe, input logic [31:0] e_baddr,
                        input logic [3:0] e_sel, input logic [31:0] e_bwdata,
                        input logic e_mwe, input logic [31:0] e_mwdata,
                        input logic e_llwe, input logic e_llval);
    ex_memop = op; ex_memaddr = addr; ex_memdata = data;
    @(negedge clk);
    chk(nm, "decode_stall", 32'(stallreq_mem), 1);
    chk(nm, "decode_req", 32'(dbus_req), 0);
    tick();
    chk(nm, "req", 32'(dbus_req), 1);
    chk(nm, "bus_we", 32'(dbus_we), 32'(e_bwe));
    chk(nm, "bus_addr", dbus_addr, e_baddr);
    chk(nm, "bus_sel", 32'(dbus_sel), 32'(e_sel));
    if (e_bwe) chk(nm, "bus_wdata", dbus_wdata, e_bwdata);
    for (int d = 0; d < dly; d++) begin
      @(negedge clk);
      chk(nm, "wait_stall", 32'(stallreq_mem), 1);
      chk(nm, "wait_req", 32'(dbus_req), 1);
      tick();
    end
    dbus_ack = 1'b1; dbus_rdata = rdata;
    @(negedge clk);
    chk(nm, "ack_stall", 32'(stallreq_mem), 1);
    tick();
    dbus_ack = 1'b0; dbus_rdata = 32'h0BAD0BAD;
    chk(nm, "req_drop", 32'(dbus_req), 0);
    stall = (hold > 0) ? 6'b010000 : 6'b000000;
    for (int h = 0; h <= hold; h++) begin
      if (h == hold) stall = 6'b000000;
      @(negedge clk);
      chk(nm, "done_stall", 32'(stallreq_mem), 0);
      chk(nm, "mem_we", 32'(mem_we), 32'(e_mwe));
      chk(nm, "mem_wdata", mem_wdata, e_mwdata);
      chk(nm, "mem_waddr", 32'(mem_waddr), 32'(ex_waddr));
      chk(nm, "ll_we", 32'(LLbit_we_o), 32'(e_llwe));
      if (e_llwe) chk(nm, "ll_val", 32'(LLbit_value_o), 32'(e_llval));
      tick();
    end
    ex_memop = OP_NONE;
    @(negedge clk);
    chk(nm, "back_idle", mem_wdata, ex_wdata);
    tick();
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic        llb, wbwe, wbval, fl, we;
    logic [31:0] wd;
    logic        e_we;
    logic [31:0] e_wd;
    logic [4:0]  e_wa;
    logic        e_err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{OP_NONE, 32'h0,   0,0,0,0,1, 32'h12345678, 1, 32'h12345678, 5'd7, 0};
    vecs[1] = '{4'd13,   32'h100, 0,0,0,0,0, 32'hAAAA5555, 0, 32'hAAAA5555, 5'd7, 0};
    vecs[2] = '{OP_LW,   32'h102, 0,0,0,0,1, 32'h00000001, 0, 32'h00000001, 5'd7, 1};
    vecs[3] = '{OP_LH,   32'h101, 0,0,0,0,1, 32'h00000002, 0, 32'h00000002, 5'd7, 1};
    vecs[4] = '{OP_SW,   32'h003, 0,0,0,0,0, 32'h00000003, 0, 32'h00000003, 5'd7, 1};
    vecs[5] = '{OP_LL,   32'h002, 1,0,0,0,1, 32'h00000004, 0, 32'h00000004, 5'd7, 1};
    vecs[6] = '{OP_SC,   32'h010, 0,0,0,0,1, 32'h00000099, 1, 32'h00000000, 5'd7, 0};
    vecs[7] = '{OP_SC,   32'h010, 1,1,0,0,1, 32'h00000098, 1, 32'h00000000, 5'd7, 0};
    vecs[8] = '{OP_NONE, 32'h0,   0,0,0,1,1, 32'h00000077, 0, 32'h00000000, 5'd0, 0};
    vecs[9] = '{OP_LHU,  32'h103, 0,0,0,0,1, 32'h00000005, 0, 32'h00000005, 5'd7, 1};

    reset_n = 1'b0; stall = '0; flush = 1'b0;
    ex_we = 1'b1; ex_waddr = 5'd7; ex_wdata = 32'h12345678; ex_whilo = 1'b1;
    ex_hi = 32'h0000_1111; ex_lo = 32'h0000_2222;
    ex_memop = OP_NONE; ex_memaddr = '0; ex_memdata = '0;
    llbit_i = 1'b0; wb_llbit_we = 1'b0; wb_llbit_value = 1'b0;
    dbus_ack = 1'b0; dbus_rdata = '0;

    @(negedge clk);
    chk("reset", "mem_we", 32'(mem_we), 0);
    chk("reset", "mem_wdata", mem_wdata, 0);
    chk("reset", "mem_hi", mem_hi, 0);
    chk("reset", "req", 32'(dbus_req), 0);
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle", "mem_hi", mem_hi, 32'h0000_1111);
    chk("idle", "mem_whilo", 32'(mem_whilo), 1);
    tick();

    for (int i = 0; i < 10; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      ex_memop = vecs[i].op; ex_memaddr = vecs[i].addr; llbit_i = vecs[i].llb;
      wb_llbit_we = vecs[i].wbwe; wb_llbit_value = vecs[i].wbval;
      flush = vecs[i].fl; ex_we = vecs[i].we; ex_wdata = vecs[i].wd;
      @(negedge clk);
      chk(nm, "mem_we", 32'(mem_we), 32'(vecs[i].e_we));
      chk(nm, "mem_wdata", mem_wdata, vecs[i].e_wd);
      chk(nm, "mem_waddr", 32'(mem_waddr), 32'(vecs[i].e_wa));
      chk(nm, "addr_err", 32'(addr_err), 32'(vecs[i].e_err));
      chk(nm, "stallreq", 32'(stallreq_mem), 0);
      chk(nm, "ll_we", 32'(LLbit_we_o), 0);
      tick();
      chk(nm, "no_req", 32'(dbus_req), 0);
    end
    ex_memop = OP_NONE; flush = 1'b0; llbit_i = 1'b0; wb_llbit_we = 1'b0;
    ex_we = 1'b1; ex_waddr = 5'd5; ex_wdata = 32'h5A5A5A5A;
    tick();

    run_op("lw",  OP_LW,  32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0, 32'h100, 4'b1111, 32'h0,
           1, 32'hDEADBEEF, 0, 0);
    run_op("lb",  OP_LB,  32'h103, 32'h0, 32'h112233F0, 0, 0, 0, 32'h100, 4'b0001, 32'h0,
           1, 32'hFFFFFFF0, 0, 0);
    run_op("lbu", OP_LBU, 32'h103, 32'h0, 32'h112233F0, 0, 0, 0, 32'h100, 4'b0001, 32'h0,
           1, 32'h000000F0, 0, 0);
    run_op("lb1", OP_LB,  32'h101, 32'h0, 32'h11A23344, 1, 0, 0, 32'h100, 4'b0100, 32'h0,
           1, 32'hFFFFFFA2, 0, 0);
    run_op("lh2", OP_LH,  32'h102, 32'h0, 32'h1234F00D, 0, 0, 0, 32'h100, 4'b0011, 32'h0,
           1, 32'hFFFFF00D, 0, 0);
    run_op("lhu", OP_LHU, 32'h100, 32'h0, 32'h8001ABCD, 0, 2, 0, 32'h100, 4'b1100, 32'h0,
           1, 32'h00008001, 0, 0);
    run_op("lh0", OP_LH,  32'h100, 32'h0, 32'h7FFF0000, 0, 0, 0, 32'h100, 4'b1100, 32'h0,
           1, 32'h00007FFF, 0, 0);
    ex_we = 1'b0;
    run_op("sh",  OP_SH,  32'h202, 32'h0000ABCD, 32'h0, 0, 0, 1, 32'h200, 4'b0011,
           32'hABCDABCD, 0, 32'h5A5A5A5A, 0, 0);
    run_op("sb",  OP_SB,  32'h305, 32'h000000A5, 32'h0, 2, 0, 1, 32'h304, 4'b0100,
           32'hA5A5A5A5, 0, 32'h5A5A5A5A, 0, 0);
    run_op("sw",  OP_SW,  32'h040, 32'hCAFEBABE, 32'h0, 3, 0, 1, 32'h040, 4'b1111,
           32'hCAFEBABE, 0, 32'h5A5A5A5A, 0, 0);
    ex_we = 1'b1;
    run_op("ll",  OP_LL,  32'h010, 32'h0, 32'h00C0FFEE, 0, 0, 0, 32'h010, 4'b1111, 32'h0,
           1, 32'h00C0FFEE, 1, 1);
    llbit_i = 1'b0; wb_llbit_we = 1'b1; wb_llbit_value = 1'b1;
    run_op("sc",  OP_SC,  32'h010, 32'h55AA55AA, 32'h0, 0, 0, 1, 32'h010, 4'b1111,
           32'h55AA55AA, 1, 32'h00000001, 1, 0);

    // Second SC without a fresh LL fails locally.
    wb_llbit_we = 1'b0; ex_memop = OP_SC; ex_memaddr = 32'h10;
    @(negedge clk);
    chk("sc2", "mem_we", 32'(mem_we), 1);
    chk("sc2", "mem_wdata", mem_wdata, 0);
    chk("sc2", "stallreq", 32'(stallreq_mem), 0);
    tick();
    chk("sc2", "no_req", 32'(dbus_req), 0);
    ex_memop = OP_NONE;
    tick();

    // Flush while waiting on a slow ack: result discarded, back to IDLE.
    ex_wdata = 32'h11112222; ex_memop = OP_LL; ex_memaddr = 32'h20;
    @(negedge clk);
    chk("flush", "decode_stall", 32'(stallreq_mem), 1);
    tick();
    flush = 1'b1;
    for (int d = 0; d < 5; d++) begin
      @(negedge clk);
      chk("flush", "wait_stall", 32'(stallreq_mem), 1);
      chk("flush", "wait_req", 32'(dbus_req), 1);
      chk("flush", "wait_mem_we", 32'(mem_we), 0);
      chk("flush", "wait_ll_we", 32'(LLbit_we_o), 0);
      tick();
    end
    dbus_ack = 1'b1; dbus_rdata = 32'hFEEDFACE;
    @(negedge clk);
    chk("flush", "ack_stall", 32'(stallreq_mem), 1);
    tick();
    dbus_ack = 1'b0; flush = 1'b0; ex_memop = OP_NONE;
    chk("flush", "req_drop", 32'(dbus_req), 0);
    @(negedge clk);
    chk("flush", "idle_stall", 32'(stallreq_mem), 0);
    chk("flush", "idle_wdata", mem_wdata, 32'h11112222);
    chk("flush", "idle_ll_we", 32'(LLbit_we_o), 0);
    tick();

    // Reset in the middle of a transaction, followed by a stray ack.
    ex_memop = OP_LW; ex_memaddr = 32'h80;
    tick();
    chk("rst_wait", "req", 32'(dbus_req), 1);
    reset_n = 1'b0;
    #1;
    chk("rst_wait", "req_now", 32'(dbus_req), 0);
    chk("rst_wait", "stallreq", 32'(stallreq_mem), 0);
    chk("rst_wait", "mem_we", 32'(mem_we), 0);
    chk("rst_wait", "mem_wdata", mem_wdata, 0);
    ex_memop = OP_NONE;
    tick();
    reset_n = 1'b1; dbus_ack = 1'b1; dbus_rdata = 32'h99999999;
    @(negedge clk);
    chk("late_ack", "stallreq", 32'(stallreq_mem), 0);
    tick();
    dbus_ack = 1'b0;
    chk("late_ack", "req", 32'(dbus_req), 0);
    @(negedge clk);
    chk("late_ack", "mem_wdata", mem_wdata, 32'h11112222);
    chk("late_ack", "ll_we", 32'(LLbit_we_o), 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the 5-stage CPU pipeline, sitting between the EX/MEM register and the MEM/WB register. It turns load/store/LL/SC operations into single transactions on the data bus: byte-lane select, big-endian alignment, sign/zero extension and LLbit handling. It holds the pipeline with a stall request until the bus acknowledges. For non-memory instructions it passes register-file and HI/LO write-back fields straight through.

## Interface
- No parameters.
- clk  in  1  pipeline clock.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  6  pipeline stall vector; bit 4 = MEM/WB hold.
- flush  in  1  exception flush of this stage.
- ex_we, ex_waddr[4:0], ex_wdata[31:0], ex_whilo, ex_hi[31:0], ex_lo[31:0]  in  write-back fields from EX/MEM.
- ex_memop  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, 9 LL, 10 SC; 11-15 treated as none.
- ex_memaddr  in  32  effective address.
- ex_memdata  in  32  store data (rt).
- llbit_i  in  1  current LLbit register value.
- wb_llbit_we, wb_llbit_value  in  1 each  LLbit update pending in MEM/WB, forwarded.
- dbus_req  out  1  transaction request, held until ack.
- dbus_we  out  1  1 = write.
- dbus_addr  out  32  word address, {addr[31:2],2'b00}.
- dbus_sel  out  4  byte enables, bit 3 = bits [31:24].
- dbus_wdata  out  32  store data, replicated across lanes.
- dbus_ack  in  1  one-cycle completion; dbus_rdata valid in the same cycle.
- dbus_rdata  in  32  read data.
- mem_we, mem_waddr[4:0], mem_wdata[31:0], mem_whilo, mem_hi[31:0], mem_lo[31:0]  out  to MEM/WB.
- LLbit_we_o, LLbit_value_o  out  1 each  LLbit update to MEM/WB.
- stallreq_mem  out  1  request to hold the pipeline.
- addr_err  out  1  misaligned access, one-cycle pulse.

## Operation
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE; all bus registers reset to 0.
- **IDLE, memop = none:** all mem_* outputs equal the ex_* inputs. LLbit_we_o=0, stallreq_mem=0.
- **IDLE, aligned LB/LBU/LH/LHU/LW/SB/SH/SW/LL, or SC with llbit_cur=1:**
  - stallreq_mem=1.
  - Register the bus fields (dbus_req=1, we, addr, sel, wdata) and go to WAIT.
- **llbit_cur** = wb_llbit_we ? wb_llbit_value : llbit_i.
- **SC with llbit_cur=0:** no bus access.
  - Outputs mem_we=1, mem_wdata=0, LLbit_we_o=0, stallreq_mem=0.
  - Stay in IDLE.
- **Misaligned access** (halfword with addr[0]=1, word/LL/SC with addr[1:0]≠0):
  - No bus access; addr_err=1.
  - mem_we=0, LLbit_we_o=0, stallreq_mem=0.
- **Byte lanes (big-endian):**
  - Byte at offset k uses sel bit 3-k and data [31-8k:24-8k].
  - Halfword at offset 0 uses sel 1100; at offset 2 uses sel 0011.
  - Word uses sel 1111.
  - SB wdata = {4{b}}, SH wdata = {2{h}}, SW/SC wdata = data.
- **WAIT:** dbus_req held, stallreq_mem=1.
  - On dbus_ack: capture the extended load result (or 1 for SC) into a result register; drop dbus_req on the next edge; go to DONE.
- **DONE:** stallreq_mem=0.
  - mem_wdata = captured result for loads/SC, ex_wdata otherwise. Remaining fields come from ex_*.
  - LL gives LLbit_we_o=1, value 1. SC gives LLbit_we_o=1, value 0.
  - Stores give mem_we=ex_we (0).
  - Leave DONE for IDLE when stall[4]=0; stay in DONE while stall[4]=1.
- **Extension:** LB/LH sign-extend; LBU/LHU zero-extend.
- **flush:**
  - In IDLE or DONE: return to IDLE; all mem_*/LLbit outputs 0 that cycle.
  - In WAIT: the bus transaction completes. On ack go to IDLE, not DONE, and discard the result. stallreq_mem stays 1 until the ack.

## Timing
- While reset_n=0 all outputs are 0, independent of the clock.
- Bus outputs are registered. mem_*, stallreq_mem and addr_err are combinational from state and inputs.
- Minimum memory-op latency is 3 cycles:
  - Cycle 0: IDLE decode.
  - Cycle 1: WAIT, ack.
  - Cycle 2: DONE; MEM/WB captures at the end of cycle 2.
- Each extra cycle without ack adds one cycle.
- dbus_ack outside WAIT is ignored.
- Reset during WAIT drops dbus_req immediately. A late ack is then ignored.

## Test plan
- LW at 0x100 with ack in the first WAIT cycle, rdata 0xDEADBEEF, ex_waddr=5:
  - stallreq_mem high for 2 cycles.
  - In DONE: mem_we=1, mem_waddr=5, mem_wdata=0xDEADBEEF.
- LB/LBU at 0x103 with rdata 0x112233F0 → 0xFFFFFFF0 / 0x000000F0, dbus_sel=0001.
- SH at 0x202 with data 0x0000ABCD → dbus_we=1, addr 0x200, sel 0011, wdata 0xABCDABCD. mem_we=0.
- LL at 0x10, then SC at 0x10 the next instruction:
  - llbit forwarded from wb_llbit_we=1, value 1.
  - SC issues a bus write, mem_wdata=1, LLbit_we_o=1, value 0.
  - A second SC without an intervening LL gives mem_wdata=0 and no dbus_req.
- LW at 0x102 → addr_err=1 for one cycle, dbus_req stays 0, mem_we=0.
- Ack withheld for 5 cycles with flush asserted in WAIT → dbus_req held until ack, then IDLE. No mem_we or LLbit_we_o pulse.
- Reset mid-WAIT → all outputs 0 at once.
